overlay_status_ctrl: RTL

Schedules face-detection runs and drives the status inputs of the overlay draw stage: the `detected_flag` indicator and the `continuous` mode indicator. It sits between the VGA timing chain, the user buttons and the detector core. It issues a one-cycle start per detection run, filters detector results with hit/miss hysteresis, and updates its overlay outputs only at frame start so nothing tears mid-frame.

---
 rtl/overlay_status_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/overlay_status_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : overlay_status_ctrl
// Description : Schedules face-detection runs, filters detector results with
//               hit/miss hysteresis and publishes frame-synchronous overlay
//               status (detected_flag, continuous) to the draw stage.
// Revision    : 1.0 - initial release
// ============================================================================
module overlay_status_ctrl #(
  parameter int HIT_THRESH     = 2,
  parameter int MISS_THRESH    = 3,
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        mode_btn,
  input  logic        trigger_btn,
  input  logic        det_valid,
  input  logic        det_hit,
  output logic        det_start,
  output logic        busy,
  output logic        detected_flag,
  output logic        continuous,
  output logic [15:0] det_count
);

  localparam logic [3:0] C_HIT_MAX  = 4'(HIT_THRESH);
  localparam logic [3:0] C_MISS_MAX = 4'(MISS_THRESH);
  localparam logic [7:0] C_TIMEOUT  = 8'(TIMEOUT_FRAMES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_vsync_d;
  logic        w_fs;
  logic        r_mode_req;
  logic        r_armed;
  logic [7:0]  r_frame_cnt;
  logic [7:0]  w_frame_cnt_nxt;
  logic [3:0]  r_hit_cnt;
  logic [3:0]  r_miss_cnt;
  logic [3:0]  w_hit_inc;
  logic [3:0]  w_miss_inc;
  logic        r_det_state;
  logic        w_start;
  logic        w_result;
  logic        w_result_hit;
  logic        r_det_start;
  logic        r_detected_flag;
  logic        r_continuous;
  logic [15:0] r_det_count;

  // Frame start is the rising edge of vsync against its one-cycle delayed copy.
  assign w_fs = vsync_in & ~r_vsync_d;

  // Saturating increments used by the hysteresis filter.
  assign w_hit_inc  = (r_hit_cnt  >= C_HIT_MAX)  ? C_HIT_MAX  : r_hit_cnt  + 4'd1;
  assign w_miss_inc = (r_miss_cnt >= C_MISS_MAX) ? C_MISS_MAX : r_miss_cnt + 4'd1;

  // Scheduler state register and run frame counter.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  // Scheduler next-state: start on a frame start, finish on a result or timeout.
  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_start         = 1'b0;
    w_result        = 1'b0;
    w_result_hit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fs && (r_mode_req || r_armed)) begin
          w_state_nxt     = ST_RUN;
          w_start         = 1'b1;
          w_frame_cnt_nxt = 8'd0;
        end
      end
      ST_RUN: begin
        // A real result takes priority over a timeout on the same edge.
        if (det_valid) begin
          w_result     = 1'b1;
          w_result_hit = det_hit;
          w_state_nxt  = ST_IDLE;
        end else if (w_fs) begin
          if (r_frame_cnt + 8'd1 == C_TIMEOUT) begin
            w_result     = 1'b1;
            w_result_hit = 1'b0;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 8'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Mode request toggle and single-deep trigger request.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vsync_d  <= 1'b0;
      r_mode_req <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_vsync_d <= vsync_in;
      if (mode_btn) begin
        r_mode_req <= ~r_mode_req;
      end
      // A trigger on the same edge as a consume/clear is kept as a new request.
      if (trigger_btn) begin
        r_armed <= 1'b1;
      end else if ((w_start || mode_btn) && !r_mode_req) begin
        r_armed <= 1'b0;
      end
    end
  end

  // Hit/miss hysteresis and completed-run counter.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_hit_cnt   <= 4'd0;
      r_miss_cnt  <= 4'd0;
      r_det_state <= 1'b0;
      r_det_count <= 16'd0;
    end else if (w_result) begin
      r_det_count <= r_det_count + 16'd1;
      if (w_result_hit) begin
        r_miss_cnt <= 4'd0;
        r_hit_cnt  <= w_hit_inc;
        if (w_hit_inc == C_HIT_MAX) begin
          r_det_state <= 1'b1;
        end
      end else begin
        r_hit_cnt  <= 4'd0;
        r_miss_cnt <= w_miss_inc;
        if (w_miss_inc == C_MISS_MAX) begin
          r_det_state <= 1'b0;
        end
      end
    end
  end

  // Registered outputs; overlay status only moves at frame start.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_det_start     <= 1'b0;
      r_detected_flag <= 1'b0;
      r_continuous    <= 1'b0;
    end else begin
      r_det_start <= w_start;
      if (w_fs) begin
        r_detected_flag <= r_det_state;
        r_continuous    <= r_mode_req;
      end
    end
  end

  assign det_start     = r_det_start;
  assign busy          = (r_state == ST_RUN);
  assign detected_flag = r_detected_flag;
  assign continuous    = r_continuous;
  assign det_count     = r_det_count;

endmodule
`default_nettype wire
